fifo_write_arbiter: RTL

//  Round-robin arbiter sharing one FIFO write port between N requesters.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The state encodings stay fixed so older tools and waveform viewers see stable values.
package fifo_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        BURST = ST_BURST,
        STALL = ST_STALL
    } arb_state_e;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = width_of(4);
    localparam int CNT_W = width_of(4 + 1);

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first active request at or after the rotating pointer, as one-hot and index.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    // Scanning from the farthest offset back to the pointer lets the closest hit win.
    always_comb begin
        int pos;
        pos      = 0;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr_i) + k) % N;
            if (req_i[pos]) begin
                onehot_o      = '0;
                onehot_o[pos] = 1'b1;
                idx_o         = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N requesters in bursts.
// Writes are gated on full/almost-full so no word is ever lost or overwritten.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int SIZE      = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*SIZE-1:0] req_data,
    output logic [N-1:0]      ack,
    output logic [N-1:0]      grant,
    input  logic              f_flag,
    input  logic              almost_full_flag,
    output logic              valid_write,
    output logic [SIZE-1:0]   data_in
);

    localparam int PW = width_of(N);
    localparam int CW = width_of(MAX_BURST + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            valid_write_q, valid_write_d;
    logic [SIZE-1:0] data_q, data_d;

    logic [N-1:0]    pick_onehot;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            can_issue;
    logic            owner_req;
    logic [PW-1:0]   next_ptr;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // A write registered last cycle is not yet visible in almost_full, so it must count as taken.
    assign can_issue = !f_flag && !(almost_full_flag && valid_write_q);
    assign owner_req = req[owner_q];
    assign next_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        valid_write_d = 1'b0;
        data_d        = data_q;
        ack           = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_onehot;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST, STALL: begin
                if (!owner_req) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if (can_issue) begin
                    ack           = grant_q;
                    valid_write_d = 1'b1;
                    data_d        = req_data[owner_q*SIZE +: SIZE];
                    if (burst_cnt_q == LAST_CNT) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                        state_d     = BURST;
                    end
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            valid_write_q <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            valid_write_q <= valid_write_d;
            data_q        <= data_d;
        end
    end

    assign grant       = grant_q;
    assign valid_write = valid_write_q;
    assign data_in     = data_q;

endmodule
